// File: rtl/fmo_reader.sv
// fmo_reader: sweeps a contiguous, wrapping window of the FMO RAM and streams
// the elements in address order through a 4-entry FIFO towards the DMA.
// Optional feature macro: FMO_READER_RELU_EN (clamp negative signed elements
// to zero as they enter the FIFO; latency and throughput are unchanged).
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only produces a done pulse
// READ  | issuing one RAM address per cycle while FIFO + in-flight < 4
// DRAIN | all addresses issued; waiting for the last element to transfer

package ram_pkg;
    parameter int FMO_N_ELEM = 16;
    parameter int PX_W       = 8;
endpackage

module fmo_reader #(
    parameter int  FMO_N_ELEM = ram_pkg::FMO_N_ELEM,
    parameter int  PX_W       = ram_pkg::PX_W,
    localparam int AW         = $clog2(FMO_N_ELEM)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW:0]     length,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_write,
    input  logic [PX_W-1:0] ram_res,
    output logic [PX_W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    localparam int            FIFO_DEPTH = 4;
    localparam logic [AW+1:0] N_EXT      = (AW+2)'(FMO_N_ELEM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   base_q;
    logic [AW:0]     len_q;
    logic [AW:0]     issued;
    // issue_q: an address is on the RAM port this cycle; ret_q: ram_res is valid this cycle
    logic            issue_q;
    logic            ret_q;
    logic            done_q;

    logic [PX_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [1:0]      wr_ptr;
    logic [1:0]      rd_ptr;
    logic [2:0]      occ;

    logic [2:0]      load;
    logic            can_issue;
    logic            push;
    logic            pop;
    logic            last_issue;
    logic            last_xfer;
    logic [AW+1:0]   addr_sum;
    logic [AW-1:0]   addr_next;
    logic [PX_W-1:0] push_data;

    // Issue throttling, FIFO handshakes and wrapped next-address computation
    always_comb begin
        load       = occ + {2'b00, issue_q} + {2'b00, ret_q};
        can_issue  = (state == READ) && (load < 3'(FIFO_DEPTH));
        push       = ret_q;
        pop        = (occ != 3'd0) && out_ready;
        last_issue = (issued == (len_q - (AW+1)'(1)));
        // In DRAIN nothing more is coming once the pipeline is empty
        last_xfer  = (state == DRAIN) && pop && (occ == 3'd1) && !issue_q && !ret_q;
        addr_sum   = {2'b00, base_q} + {1'b0, issued};
        if (addr_sum >= N_EXT) begin
            addr_sum = addr_sum - N_EXT;
        end
        addr_next  = addr_sum[AW-1:0];
`ifdef FMO_READER_RELU_EN
        push_data  = ram_res[PX_W-1] ? '0 : ram_res;
`else
        push_data  = ram_res;
`endif
    end

    // Sweep sequencer: samples parameters on start, issues addresses, signals completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            ram_addr <= '0;
            issue_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            issue_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            // The first element is issued on the start edge itself
                            base_q   <= base_addr;
                            len_q    <= length;
                            ram_addr <= base_addr;
                            issued   <= (AW+1)'(1);
                            issue_q  <= 1'b1;
                            state    <= (length == (AW+1)'(1)) ? DRAIN : READ;
                        end
                    end
                end
                READ: begin
                    if (can_issue) begin
                        ram_addr <= addr_next;
                        issued   <= issued + (AW+1)'(1);
                        issue_q  <= 1'b1;
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_xfer) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM read-return tracking: data arrives one cycle after the address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_q <= 1'b0;
        end else begin
            ret_q <= issue_q;
        end
    end

    // Output FIFO: push returning RAM data, pop on downstream transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            occ <= occ + {2'b00, push} - {2'b00, pop};
        end
    end

    assign out_data  = fifo_mem[rd_ptr];
    assign out_valid = (occ != 3'd0);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign ram_write = 1'b0;

endmodule

// File: doc/fmo_reader.md
FMO_READER -- requirements
Module: fmo_reader

Interface
REQ-001 Parameters FMO_N_ELEM (from ram_pkg): FMO RAM depth in elements; PX_W (from ram_pkg): pixel width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a read sweep; sampled only in IDLE.
REQ-005 base_addr  input  $clog2(FMO_N_ELEM)  first element address; sampled with start.
REQ-006 length  input  $clog2(FMO_N_ELEM)+1  element count, 0..FMO_N_ELEM; sampled with start.
REQ-007 ram_addr  output  $clog2(FMO_N_ELEM)  address to the FMO RAM port.
REQ-008 ram_write  output  1  FMO RAM write enable; constant 0.
REQ-009 ram_res  input  PX_W  FMO RAM read data; valid one cycle after ram_addr is presented with ram_write=0.
REQ-010 out_data  output  PX_W  stream data towards the DMA.
REQ-011 out_valid  output  1  out_data holds an element.
REQ-012 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-013 busy  output  1  sweep in progress (state != IDLE).
REQ-014 done  output  1  one-cycle pulse at sweep completion.

Function
REQ-015 States: IDLE, READ, DRAIN; IDLE->READ on start with length>0; IDLE->IDLE with done pulse on the next cycle when start has length==0.
REQ-016 READ issues one address per cycle (ram_addr = (base_addr + issued) mod FMO_N_ELEM) while occupancy + in_flight < 4; otherwise holds ram_addr.
REQ-017 Each issued read returns ram_res one cycle later; ram_res is pushed into a 4-entry output FIFO on the following edge (2 cycles issue-to-push).
REQ-018 READ->DRAIN after the issue for element length-1; DRAIN->IDLE on the edge where the last element transfers; done=1 and busy=0 in the cycle after that edge.
REQ-019 First out_valid rises 2 cycles after the start edge; with out_ready held high, throughput is one element per cycle and the sweep of N elements completes in N+2 cycles.
REQ-020 Elements are emitted strictly in address order; none are dropped or duplicated under any out_ready pattern.
REQ-021 out_data/out_valid hold stable while out_valid && !out_ready.
REQ-022 Address wrap: base_addr + offset >= FMO_N_ELEM wraps to 0.
REQ-023 start while busy is ignored; no new parameters are sampled.
REQ-024 Push and pop in the same cycle leave occupancy unchanged; FIFO never overflows (guaranteed by REQ-016).

Reset
REQ-025 On rst_n low, immediately: state IDLE, FIFO empty, in_flight 0, ram_addr 0, out_valid 0, out_data 0, busy 0, done 0.
REQ-026 Reset mid-sweep abandons the sweep; ram_res returning after reset is discarded; no done pulse is generated.

Configuration
REQ-027 Macro FMO_READER_RELU_EN: when defined, each element is treated as signed PX_W and negative values are replaced by 0 at FIFO push; when undefined, out_data equals ram_res bit-exact.
REQ-028 Latency and throughput are identical with and without FMO_READER_RELU_EN.

Verification
REQ-029 RAM preloaded mem[i]=i, base 0, length 8, out_ready=1 -> out_valid high from cycle 2, data 0..7 on consecutive cycles, done pulse after the 8th transfer.
REQ-030 FMO_N_ELEM=16, base 14, length 4 -> data from addresses 14,15,0,1 in order.
REQ-031 length 8, out_ready toggled 1,0,0,1 repeating -> all 8 values in order, out_data stable while stalled, ram_addr stalls when FIFO+in_flight=4.
REQ-032 start with length 0 -> no out_valid, done pulses once on the next cycle, busy stays 0.
REQ-033 rst_n low after 3 transfers of a length-8 sweep -> all outputs 0 asynchronously; new start, base 0, length 2 -> exactly values 0,1.
REQ-034 FMO_READER_RELU_EN defined, mem = {-3, 5, -128, 0} (PX_W=8) -> out_data 0,5,0,0; undefined -> 0xFD,0x05,0x80,0x00.
